mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported memory between an instruction-fetch requester (I)
// and a data load/store requester (D). Requests are only looked at while the
// arbiter is idle; once a side is granted its address/store data are latched
// and the memory command is driven until mem_ready or until the timeout
// counter expires. Completion is reported with a one-cycle valid pulse on the
// granted side (plus err on timeout). Conflicts alternate between I and D.
//
// Parameters
//   ADDR_W   word address width
//   DATA_W   memory data width (must be >= 32)
//   TIMEOUT  number of busy cycles waited for mem_ready before giving up
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_req, i_addr            instruction fetch request (held until i_valid)
//   i_rdata, i_valid         fetched word (low 32 bits of memory), done pulse
//   d_req, d_wen, d_addr,    data request: store when d_wen=1, else load
//   d_wdata
//   d_rdata, d_valid         load data, done pulse
//   err                      accompanies a valid pulse when the access timed out
//   busy                     high whenever the arbiter is not idle
//   mem_read, mem_write,     memory command, address and store data
//   mem_addr, mem_wdata
//   mem_rdata, mem_ready     memory read data and completion strobe
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              err,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // A timeout of zero makes no sense; treat it as one busy cycle.
  localparam int TMO_EFF = (TIMEOUT < 1) ? 1 : TIMEOUT;
  // The counter only has to reach TMO_EFF-1 (the last busy cycle).
  localparam int CNT_W = (TMO_EFF < 2) ? 1 : $clog2(TMO_EFF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_EFF - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] D_BUSY = 2'd1;
  localparam logic [1:0] I_BUSY = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              last_grant_r;   // side granted most recently
  logic              gnt_d_r;        // side owning the current access
  logic              wen_r;          // current access is a store
  logic [CNT_W-1:0]  cnt_r;          // busy cycles spent so far, minus one

  logic              take_d_s;
  logic              take_i_s;
  logic              done_s;
  logic              tmo_s;

  logic [31:0]       i_rdata_r;
  logic              i_valid_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              d_valid_r;
  logic              err_r;
  logic              busy_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  // Next-state decision: arbitration in IDLE, completion/timeout while busy.
  always_comb begin
    state_nxt_s = state_r;
    take_d_s    = 1'b0;
    take_i_s    = 1'b0;
    done_s      = 1'b0;
    tmo_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_req && i_req) begin
          // Conflict: the side that did not win last time gets the grant.
          if (last_grant_r == GNT_I) begin
            take_d_s    = 1'b1;
            state_nxt_s = D_BUSY;
          end else begin
            take_i_s    = 1'b1;
            state_nxt_s = I_BUSY;
          end
        end else if (d_req) begin
          take_d_s    = 1'b1;
          state_nxt_s = D_BUSY;
        end else if (i_req) begin
          take_i_s    = 1'b1;
          state_nxt_s = I_BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      D_BUSY, I_BUSY: begin
        // A ready on the last allowed cycle still counts as a real completion.
        if (mem_ready) begin
          done_s      = 1'b1;
          state_nxt_s = RESP;
        end else if (cnt_r == CNT_LAST) begin
          tmo_s       = 1'b1;
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= GNT_I;
      gnt_d_r      <= GNT_I;
      wen_r        <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      i_rdata_r    <= 32'h0;
      i_valid_r    <= 1'b0;
      d_rdata_r    <= {DATA_W{1'b0}};
      d_valid_r    <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
      // Valid/err are only ever high for the single RESP cycle.
      i_valid_r <= (done_s | tmo_s) & (gnt_d_r == GNT_I);
      d_valid_r <= (done_s | tmo_s) & (gnt_d_r == GNT_D);
      err_r     <= tmo_s;

      if (take_d_s | take_i_s) begin
        // Latch everything needed now; requester inputs are ignored afterwards.
        gnt_d_r      <= take_d_s;
        last_grant_r <= take_d_s;
        wen_r        <= take_d_s & d_wen;
        cnt_r        <= {CNT_W{1'b0}};
        mem_addr_r   <= take_d_s ? d_addr : i_addr;
        mem_read_r   <= take_i_s | (take_d_s & ~d_wen);
        mem_write_r  <= take_d_s & d_wen;
        if (take_d_s) begin
          mem_wdata_r <= d_wdata;
        end
      end else if (done_s | tmo_s) begin
        mem_read_r  <= 1'b0;
        mem_write_r <= 1'b0;
        if (tmo_s) begin
          // Nothing trustworthy came back: hand the requester zeros.
          if (gnt_d_r == GNT_D) begin
            d_rdata_r <= {DATA_W{1'b0}};
          end else begin
            i_rdata_r <= 32'h0;
          end
        end else if (gnt_d_r == GNT_D) begin
          // A store leaves the previous load data in place.
          if (!wen_r) begin
            d_rdata_r <= mem_rdata;
          end
        end else begin
          i_rdata_r <= mem_rdata[31:0];
        end
      end else if (state_r == D_BUSY || state_r == I_BUSY) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
    end
  end

  assign i_rdata   = i_rdata_r;
  assign i_valid   = i_valid_r;
  assign d_rdata   = d_rdata_r;
  assign d_valid   = d_valid_r;
  assign err       = err_r;
  assign busy      = busy_r;
  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (TIMEOUT=4). Inputs are driven and
// outputs sampled on the falling clock edge. Sections: reset values, a
// cycle-by-cycle vector table (load, stray ready, back-to-back fetch, store,
// timeout), reset in the middle of an access, the alternating conflict
// order, and a randomized run against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW  = 30;
  localparam int DW  = 64;
  localparam int TMO = 4;

  localparam logic [29:0] A_D = 30'h10;
  localparam logic [29:0] A_I = 30'h100;
  localparam logic [63:0] MR  = 64'h1122334455667788;
  localparam logic [31:0] MRL = 32'h55667788;
  localparam logic [63:0] WD  = 64'hDEADBEEF01234567;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          i_valid;
  logic          d_req;
  logic          d_wen;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          err;
  logic          busy;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .err(err), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_i_rdata"},   i_rdata,   64'h0);
    chk({nm, "_i_valid"},   i_valid,   64'h0);
    chk({nm, "_d_rdata"},   d_rdata,   64'h0);
    chk({nm, "_d_valid"},   d_valid,   64'h0);
    chk({nm, "_err"},       err,       64'h0);
    chk({nm, "_busy"},      busy,      64'h0);
    chk({nm, "_mem_read"},  mem_read,  64'h0);
    chk({nm, "_mem_write"}, mem_write, 64'h0);
    chk({nm, "_mem_addr"},  mem_addr,  64'h0);
    chk({nm, "_mem_wdata"}, mem_wdata, 64'h0);
  endtask

  // One table row: inputs applied this cycle and outputs expected this cycle.
  typedef struct packed {
    logic [3:0]  in;    // {i_req, d_req, d_wen, mem_ready}
    logic [5:0]  ex;    // {busy, mem_read, mem_write, i_valid, d_valid, err}
    logic [29:0] addr;  // mem_addr, checked only while a command is out
    logic [31:0] ir;
    logic [63:0] dr;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] in, input logic [5:0] ex,
                              input logic [29:0] a, input logic [31:0] ir,
                              input logic [63:0] dr);
    vec_t v;
    v.in = in; v.ex = ex; v.addr = a; v.ir = ir; v.dr = dr;
    return v;
  endfunction

  vec_t tbl[24];

  // Reference model state for the random run.
  int          c, g, lc, t_rdy, free_c, lat;
  bit          act, t_d, t_wen, t_tmo, last_d, in_cmd, in_v, e_rd, e_wr;
  logic [29:0] t_addr;
  logic [63:0] t_wd, t_rd, d_exp;
  bit          d_known, i_gr, d_gr;
  int          i_pd, d_pd, i_cool, d_cool;
  int          order[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(4'b0100, 6'b000000, 30'h0, 32'h0, 64'h0);
    tbl[1]  = mk(4'b0100, 6'b110000, A_D,   32'h0, 64'h0);
    tbl[2]  = mk(4'b0100, 6'b110000, A_D,   32'h0, 64'h0);
    tbl[3]  = mk(4'b0100, 6'b110000, A_D,   32'h0, 64'h0);
    tbl[4]  = mk(4'b0101, 6'b110000, A_D,   32'h0, 64'h0);
    tbl[5]  = mk(4'b0100, 6'b100010, 30'h0, 32'h0, MR);
    tbl[6]  = mk(4'b0001, 6'b000000, 30'h0, 32'h0, MR);
    tbl[7]  = mk(4'b1000, 6'b000000, 30'h0, 32'h0, MR);
    tbl[8]  = mk(4'b1001, 6'b110000, A_I,   32'h0, MR);
    tbl[9]  = mk(4'b1000, 6'b100100, 30'h0, MRL,   MR);
    tbl[10] = mk(4'b1000, 6'b000000, 30'h0, MRL,   MR);
    tbl[11] = mk(4'b1001, 6'b110000, A_I,   MRL,   MR);
    tbl[12] = mk(4'b1000, 6'b100100, 30'h0, MRL,   MR);
    tbl[13] = mk(4'b0110, 6'b000000, 30'h0, MRL,   MR);
    tbl[14] = mk(4'b0111, 6'b101000, A_D,   MRL,   MR);
    tbl[15] = mk(4'b0110, 6'b100010, 30'h0, MRL,   MR);
    tbl[16] = mk(4'b1000, 6'b000000, 30'h0, MRL,   MR);
    tbl[17] = mk(4'b1000, 6'b110000, A_I,   MRL,   MR);
    tbl[18] = mk(4'b1000, 6'b110000, A_I,   MRL,   MR);
    tbl[19] = mk(4'b1000, 6'b110000, A_I,   MRL,   MR);
    tbl[20] = mk(4'b1000, 6'b110000, A_I,   MRL,   MR);
    tbl[21] = mk(4'b1001, 6'b100101, 30'h0, 32'h0, MR);
    tbl[22] = mk(4'b0000, 6'b000000, 30'h0, 32'h0, MR);
    tbl[23] = mk(4'b0000, 6'b000000, 30'h0, 32'h0, MR);

    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
    i_addr = 30'h0; d_addr = 30'h0; d_wdata = 64'h0;
    mem_rdata = 64'h0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");

    // ---------------- vector table ----------------
    i_addr = A_I; d_addr = A_D; d_wdata = WD; mem_rdata = MR;
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("tbl%0d_busy", k),  busy,      tbl[k].ex[5]);
      chk($sformatf("tbl%0d_rd", k),    mem_read,  tbl[k].ex[4]);
      chk($sformatf("tbl%0d_wr", k),    mem_write, tbl[k].ex[3]);
      chk($sformatf("tbl%0d_iv", k),    i_valid,   tbl[k].ex[2]);
      chk($sformatf("tbl%0d_dv", k),    d_valid,   tbl[k].ex[1]);
      chk($sformatf("tbl%0d_err", k),   err,       tbl[k].ex[0]);
      chk($sformatf("tbl%0d_irdata", k), i_rdata,  tbl[k].ir);
      chk($sformatf("tbl%0d_drdata", k), d_rdata,  tbl[k].dr);
      if (tbl[k].ex[4] || tbl[k].ex[3]) chk($sformatf("tbl%0d_addr", k), mem_addr, tbl[k].addr);
      if (tbl[k].ex[3]) chk($sformatf("tbl%0d_wdata", k), mem_wdata, WD);
      {i_req, d_req, d_wen, mem_ready} = tbl[k].in;
      @(negedge clk);
    end

    // ---------------- reset in the middle of a fetch ----------------
    i_addr = 30'h2A; i_req = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    chk("mid_pre_busy", busy, 64'h1);
    chk("mid_pre_rd", mem_read, 64'h1);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0; mem_rdata = 64'hCAFEF00D12345678;
    @(negedge clk);
    chk("post_rst_rd", mem_read, 64'h1);
    chk("post_rst_addr", mem_addr, 64'h2A);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("post_rst_iv", i_valid, 64'h1);
    chk("post_rst_irdata", i_rdata, 64'h12345678);
    chk("post_rst_err", err, 64'h0);
    chk("post_rst_rd_drop", mem_read, 64'h0);
    @(negedge clk);
    i_req = 1'b0;
    chk("post_rst_iv_pulse", i_valid, 64'h0);
    chk("post_rst_idle", busy, 64'h0);

    // ---------------- conflict order D,I,D,I ----------------
    @(negedge clk);
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_wen = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 60 && order.size() < 4; n++) begin
      @(negedge clk);
      chk("conflict_overlap", i_valid & d_valid, 64'h0);
      if (d_valid) order.push_back(1);
      if (i_valid) order.push_back(0);
      mem_ready = mem_read | mem_write;
    end
    chk("conflict_count", order.size(), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("conflict_order%0d", k), (k < order.size()) ? order[k] : 2, (k % 2 == 0) ? 1 : 0);
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;

    // ---------------- randomized run against the model ----------------
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    act = 1'b0; free_c = 0; last_d = 1'b0; d_exp = 64'h0; d_known = 1'b1;
    i_gr = 1'b0; d_gr = 1'b0; i_pd = 0; d_pd = 0; i_cool = 0; d_cool = 0;
    g = 0; lc = 0; t_rdy = -1; t_d = 1'b0; t_wen = 1'b0; t_tmo = 1'b0;
    t_addr = 30'h0; t_wd = 64'h0; t_rd = 64'h0;
    for (c = 0; c < 1500; c++) begin
      // 1. compare this cycle's outputs with the transaction being modelled
      in_cmd = act && c > g && c <= lc;
      in_v   = act && c == lc + 1;
      e_rd   = in_cmd && (!t_d || !t_wen);
      e_wr   = in_cmd && t_d && t_wen;
      chk("r_rd",   mem_read,  e_rd);
      chk("r_wr",   mem_write, e_wr);
      chk("r_busy", busy,      in_cmd || in_v);
      chk("r_iv",   i_valid,   in_v && !t_d);
      chk("r_dv",   d_valid,   in_v && t_d);
      chk("r_err",  err,       in_v && t_tmo);
      if (in_cmd) chk("r_addr", mem_addr, t_addr);
      if (e_wr) chk("r_wdata", mem_wdata, t_wd);
      if (in_v) begin
        if (!t_d) begin
          chk("r_irdata", i_rdata, t_tmo ? 64'h0 : {32'h0, t_rd[31:0]});
          i_gr = 1'b0; i_pd = 2;
        end else begin
          if (t_tmo && t_wen) begin
            d_known = 1'b0;
          end else if (t_tmo || !t_wen) begin
            d_exp = t_tmo ? 64'h0 : t_rd;
            d_known = 1'b1;
            chk("r_drdata", d_rdata, d_exp);
          end else if (d_known) begin
            chk("r_drdata_store", d_rdata, d_exp);
          end
          d_gr = 1'b0; d_pd = 2;
        end
        act = 1'b0; free_c = c + 1;
      end
      // 2. requesters: hold while waiting, scramble once granted
      if (i_pd == 2) i_pd = 1;
      else if (i_pd == 1) begin
        i_pd = 0;
        if ($urandom_range(0, 3) == 0) i_addr = AW'($urandom);
        else begin i_req = 1'b0; i_cool = $urandom_range(0, 3); end
      end else if (i_gr) i_addr = AW'($urandom);
      else if (!i_req) begin
        if (i_cool > 0) i_cool--;
        else if ($urandom_range(0, 1) == 1) begin i_req = 1'b1; i_addr = AW'($urandom); end
      end
      if (d_pd == 2) d_pd = 1;
      else if (d_pd == 1) begin
        d_pd = 0;
        if ($urandom_range(0, 3) == 0) begin
          d_addr = AW'($urandom); d_wen = $urandom_range(0, 1) == 1; d_wdata = {$urandom, $urandom};
        end else begin d_req = 1'b0; d_cool = $urandom_range(0, 3); end
      end else if (d_gr) begin
        d_addr = AW'($urandom); d_wen = $urandom_range(0, 1) == 1; d_wdata = {$urandom, $urandom};
      end else if (!d_req) begin
        if (d_cool > 0) d_cool--;
        else if ($urandom_range(0, 1) == 1) begin
          d_req = 1'b1; d_addr = AW'($urandom); d_wen = $urandom_range(0, 1) == 1;
          d_wdata = {$urandom, $urandom};
        end
      end
      // 3. memory: answer at the chosen latency, stray readies when idle
      mem_rdata = {$urandom, $urandom};
      if (in_cmd && !t_tmo && c == t_rdy) begin
        mem_ready = 1'b1; t_rd = mem_rdata;
      end else if (!in_cmd) mem_ready = ($urandom_range(0, 3) == 0);
      else mem_ready = 1'b0;
      // 4. arbitration: D wins unless I also asks and D won last time
      if (!act && c >= free_c && (i_req || d_req)) begin
        t_d = d_req && (!i_req || !last_d);
        last_d = t_d; g = c;
        if (t_d) begin t_wen = d_wen; t_addr = d_addr; t_wd = d_wdata; d_gr = 1'b1; end
        else begin t_wen = 1'b0; t_addr = i_addr; i_gr = 1'b1; end
        lat = $urandom_range(0, 5);
        if (lat < TMO) begin t_tmo = 1'b0; t_rdy = g + 1 + lat; lc = t_rdy; end
        else begin t_tmo = 1'b1; t_rdy = -1; lc = g + TMO; end
        act = 1'b1;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
